// File: rtl/tile_display_pipe.sv
// Tile-mapped VGA display pipe: internal VGA timing, per-frame scroll with map wrap,
// and a three-stage fetch (map address -> glyph address -> colour) advanced by pix_ce.
module tile_display_pipe #(
    parameter int H_VISIBLE     = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter bit SYNC_POL      = 1'b0,
    parameter int TILE_BITS     = 4,
    parameter int CHAR_BITS     = 3,
    parameter int MAP_COLS_LOG2 = 6,
    parameter int MAP_ROWS_LOG2 = 5
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 pix_ce,
    input  logic [MAP_COLS_LOG2+TILE_BITS-1:0]   scroll_x,
    input  logic [MAP_ROWS_LOG2+TILE_BITS-1:0]   scroll_y,
    input  logic [CHAR_BITS-1:0]                 character,
    input  logic [7:0]                           colorValue,
    output logic [MAP_COLS_LOG2+MAP_ROWS_LOG2-1:0] screenAddr,
    output logic [CHAR_BITS+2*TILE_BITS-1:0]     bitmapAddr,
    output logic [2:0]                           red,
    output logic [2:0]                           green,
    output logic [1:0]                           blue,
    output logic                                 hsync,
    output logic                                 vsync,
    output logic                                 frame_tick
);

    localparam int HT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HC_W  = $clog2(HT);
    localparam int VC_W  = $clog2(VT);
    localparam int MX_W  = MAP_COLS_LOG2 + TILE_BITS;
    localparam int MY_W  = MAP_ROWS_LOG2 + TILE_BITS;
    localparam int SA_W  = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
    localparam int BA_W  = CHAR_BITS + 2*TILE_BITS;
    localparam int HS_LO = H_VISIBLE + H_FRONT;
    localparam int HS_HI = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VS_LO = V_VISIBLE + V_FRONT;
    localparam int VS_HI = V_VISIBLE + V_FRONT + V_SYNC;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic first;
    } side_t;

    logic [HC_W-1:0]      r_hc;
    logic [VC_W-1:0]      r_vc;
    logic [MX_W-1:0]      r_sx_l;
    logic [MY_W-1:0]      r_sy_l;

    logic                 w_h_last;
    logic                 w_v_last;
    logic                 w_first;
    logic                 w_act;
    logic                 w_hs;
    logic                 w_vs;
    logic [MX_W-1:0]      w_sx;
    logic [MY_W-1:0]      w_sy;
    logic [MX_W-1:0]      w_mx;
    logic [MY_W-1:0]      w_my;
    side_t                w_side0;

    logic [SA_W-1:0]      r_sa;
    logic [TILE_BITS-1:0] r_fx1;
    logic [TILE_BITS-1:0] r_fy1;
    side_t                r_side1;
    logic [BA_W-1:0]      r_ba;
    side_t                r_side2;
    logic [2:0]           r_red;
    logic [2:0]           r_green;
    logic [1:0]           r_blue;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_ft;

    // S0: raster counters
    assign w_h_last = (int'(r_hc) == HT - 1);
    assign w_v_last = (int'(r_vc) == VT - 1);
    assign w_first  = (r_hc == '0) && (r_vc == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (pix_ce) begin
            if (w_h_last) begin
                r_hc <= '0;
                r_vc <= w_v_last ? '0 : r_vc + 1'b1;
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    assign w_act = (int'(r_hc) < H_VISIBLE) && (int'(r_vc) < V_VISIBLE);
    assign w_hs  = (int'(r_hc) >= HS_LO) && (int'(r_hc) < HS_HI);
    assign w_vs  = (int'(r_vc) >= VS_LO) && (int'(r_vc) < VS_HI);
    assign w_side0 = {w_act, w_hs, w_vs, w_first};

    // Pixel (0,0) already uses the freshly captured scroll so a whole frame shares one offset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sx_l <= '0;
            r_sy_l <= '0;
        end else if (pix_ce && w_first) begin
            r_sx_l <= scroll_x;
            r_sy_l <= scroll_y;
        end
    end

    assign w_sx = w_first ? scroll_x : r_sx_l;
    assign w_sy = w_first ? scroll_y : r_sy_l;
    assign w_mx = MX_W'(r_hc) + w_sx;
    assign w_my = MY_W'(r_vc) + w_sy;

    // S1: tile-map address and in-tile offsets
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sa    <= '0;
            r_fx1   <= '0;
            r_fy1   <= '0;
            r_side1 <= '0;
        end else if (pix_ce) begin
            r_sa    <= w_act ? {w_my[MY_W-1:TILE_BITS], w_mx[MX_W-1:TILE_BITS]} : '0;
            r_fx1   <= w_mx[TILE_BITS-1:0];
            r_fy1   <= w_my[TILE_BITS-1:0];
            r_side1 <= w_side0;
        end
    end

    // S2: glyph address from the returned character code
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ba    <= '0;
            r_side2 <= '0;
        end else if (pix_ce) begin
            r_ba    <= r_side1.act ? {character, r_fy1, r_fx1} : '0;
            r_side2 <= r_side1;
        end
    end

    // S3: colour and syncs leave together so porch widths survive at the pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
        end else if (pix_ce) begin
            r_red   <= r_side2.act ? colorValue[7:5] : 3'd0;
            r_green <= r_side2.act ? colorValue[4:2] : 3'd0;
            r_blue  <= r_side2.act ? colorValue[1:0] : 2'd0;
            r_hsync <= r_side2.hs ? SYNC_POL : ~SYNC_POL;
            r_vsync <= r_side2.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Tick drops on the next clk even when pix_ce is low, so it spans one enabled slot only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_ft <= 1'b0;
        else          r_ft <= pix_ce & r_side2.first;
    end

    assign screenAddr = r_sa;
    assign bitmapAddr = r_ba;
    assign red        = r_red;
    assign green      = r_green;
    assign blue       = r_blue;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign frame_tick = r_ft;

endmodule
